// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Purpose: groups the request, response and return-data signals that pass
//          between the two caches, the arbiter and memory.
// Signals:
//   dc_command/dc_addr/dc_data   dcache request (command, address, store data)
//   ic_command/ic_addr           icache request (loads only)
//   mem_response/mem_data/mem_tag memory accept tag, returned data, return tag
//   mem_command/mem_addr/mem_data_out  request forwarded to memory
//   dc_response/dc_tag           accept tag / return tag routed to dcache
//   ic_response/ic_tag           accept tag / return tag routed to icache
//   rsp_data                     returned data broadcast to both caches
//   outstanding                  number of tags awaiting return
//   tag_error                    sticky: data came back for an unowned tag
// Modports: slave = arbiter side, master = cache/memory (testbench) side.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      dc_command;
    logic [XLEN-1:0] dc_addr;
    logic [63:0]     dc_data;
    logic [1:0]      ic_command;
    logic [XLEN-1:0] ic_addr;
    logic [3:0]      mem_response;
    logic [63:0]     mem_data;
    logic [3:0]      mem_tag;
    logic [1:0]      mem_command;
    logic [XLEN-1:0] mem_addr;
    logic [63:0]     mem_data_out;
    logic [3:0]      dc_response;
    logic [3:0]      dc_tag;
    logic [3:0]      ic_response;
    logic [3:0]      ic_tag;
    logic [63:0]     rsp_data;
    logic [3:0]      outstanding;
    logic            tag_error;

    modport slave (
        input  dc_command, dc_addr, dc_data, ic_command, ic_addr,
        input  mem_response, mem_data, mem_tag,
        output mem_command, mem_addr, mem_data_out,
        output dc_response, dc_tag, ic_response, ic_tag,
        output rsp_data, outstanding, tag_error
    );

    modport master (
        output dc_command, dc_addr, dc_data, ic_command, ic_addr,
        output mem_response, mem_data, mem_tag,
        input  mem_command, mem_addr, mem_data_out,
        input  dc_response, dc_tag, ic_response, ic_tag,
        input  rsp_data, outstanding, tag_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose: shares one memory port between dcache and icache. dcache has
//          priority unless icache has been denied STARVE_LIMIT consecutive
//          cycles. Accepted loads are recorded in a 15-entry owner table so
//          returned data tags can be steered to the cache that issued them.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    mem_arbiter_if.slave: cache requests, memory request/response,
//          per-cache response/tag routing, outstanding count, tag_error
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned XLEN         = 32
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam logic [1:0] LP_LIMIT = 2'(STARVE_LIMIT);

    // Owner table; index 0 is never allocated since tag 0 means "none".
    logic [15:0] r_valid;
    logic [15:0] r_owner;          // 0 = dcache, 1 = icache
    logic [3:0]  r_outstanding;
    logic [1:0]  r_starve;
    logic        r_tag_error;

    logic            w_dc_req;
    logic            w_ic_req;
    logic            w_grant_dc;
    logic            w_grant_ic;
    logic            w_ic_accepted;
    logic            w_alloc;
    logic            w_ret_hit;
    logic            w_ret_owner;
    logic [1:0]      w_mem_command;
    logic [XLEN-1:0] w_mem_addr;
    logic [63:0]     w_mem_data_out;

    assign w_dc_req = (bus.dc_command != BUS_NONE);
    assign w_ic_req = (bus.ic_command != BUS_NONE);

    // icache wins over a dcache request only once it has been starved.
    assign w_grant_ic    = w_ic_req && (!w_dc_req || (r_starve == LP_LIMIT));
    assign w_grant_dc    = w_dc_req && !w_grant_ic;
    assign w_ic_accepted = w_grant_ic && (bus.mem_response != 4'd0);

    always_comb begin
        w_mem_command  = BUS_NONE;
        w_mem_addr     = '0;
        w_mem_data_out = '0;
        if (w_grant_dc) begin
            w_mem_command  = bus.dc_command;
            w_mem_addr     = bus.dc_addr;
            w_mem_data_out = bus.dc_data;
        end else if (w_grant_ic) begin
            w_mem_command  = bus.ic_command;
            w_mem_addr     = bus.ic_addr;
        end
    end

    assign bus.mem_command  = w_mem_command;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_data_out = w_mem_data_out;

    assign bus.dc_response = w_grant_dc ? bus.mem_response : 4'd0;
    assign bus.ic_response = w_grant_ic ? bus.mem_response : 4'd0;

    // Only accepted loads expect data back; stores allocate nothing.
    assign w_alloc = (w_mem_command == BUS_LOAD) && (bus.mem_response != 4'd0);

    assign w_ret_hit   = (bus.mem_tag != 4'd0) && r_valid[bus.mem_tag];
    assign w_ret_owner = r_owner[bus.mem_tag];

    assign bus.dc_tag   = (w_ret_hit && !w_ret_owner) ? bus.mem_tag : 4'd0;
    assign bus.ic_tag   = (w_ret_hit &&  w_ret_owner) ? bus.mem_tag : 4'd0;
    assign bus.rsp_data = bus.mem_data;

    assign bus.outstanding = r_outstanding;
    assign bus.tag_error   = r_tag_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid       <= '0;
            r_owner       <= '0;
            r_outstanding <= '0;
            r_starve      <= '0;
            r_tag_error   <= 1'b0;
        end else begin
            // Free first, allocate second: when both hit the same tag the
            // later assignment wins and the entry stays valid for the new owner.
            if (w_ret_hit) begin
                r_valid[bus.mem_tag] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[bus.mem_response] <= 1'b1;
                r_owner[bus.mem_response] <= w_grant_ic;
            end

            case ({w_alloc, w_ret_hit})
                2'b10:   if (r_outstanding != 4'd15) r_outstanding <= r_outstanding + 4'd1;
                2'b01:   if (r_outstanding != 4'd0)  r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if ((bus.mem_tag != 4'd0) && !w_ret_hit) begin
                r_tag_error <= 1'b1;
            end

            if (!w_ic_req || w_ic_accepted) begin
                r_starve <= '0;
            end else if (r_starve != LP_LIMIT) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Purpose: self-checking bench for mem_arbiter. Each scenario task drives
//          stimulus, pushes the expected combinational outputs to a
//          scoreboard queue and pops/compares them half a cycle later.
//          Registered outputs are checked just after the following edge.
// Ports: none (top-level bench).
module tb_mem_arbiter;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(
        .STARVE_LIMIT (3),
        .XLEN         (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // {mem_command, mem_addr, mem_data_out, dc_response, ic_response, dc_tag, ic_tag}
    typedef logic [113:0] exp_t;
    exp_t sb[$];
    exp_t e;
    exp_t obs;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t pack_exp(input logic [1:0] cmd, input logic [31:0] addr,
                                      input logic [63:0] dout, input logic [3:0] dcr,
                                      input logic [3:0] icr, input logic [3:0] dct,
                                      input logic [3:0] ict);
        return {cmd, addr, dout, dcr, icr, dct, ict};
    endfunction

    task automatic drive(input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                         input logic [1:0] icc, input logic [31:0] ica,
                         input logic [3:0] rsp, input logic [3:0] tag);
        bus.dc_command   = dcc;
        bus.dc_addr      = dca;
        bus.dc_data      = dcd;
        bus.ic_command   = icc;
        bus.ic_addr      = ica;
        bus.mem_response = rsp;
        bus.mem_tag      = tag;
        bus.mem_data     = 64'h0123_4567_89AB_CDEF ^ {60'd0, tag};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd3, 4'd0);
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding);
        end
        checks++;
        if (bus.tag_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_tag_error got=%0b exp=0", bus.tag_error);
        end
        sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_idle_outputs got=%h exp=%h", obs, e);
        end
        checks++;
        if (bus.rsp_data !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL rsp_data_passthru got=%h exp=0123456789abcdef", bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_basic_load();
        drive(2'd1, 32'h100, 64'h0, 2'd1, 32'h200, 4'd3, 4'd0);
        sb.push_back(pack_exp(2'd1, 32'h100, 64'h0, 4'd3, 4'd0, 4'd0, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL basic_grant got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd3);
        checks++;
        if (bus.outstanding !== 4'd1) begin
            errors++;
            $display("FAIL basic_outstanding_1 got=%0d exp=1", bus.outstanding);
        end
        sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0, 4'd3, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL basic_return got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL basic_outstanding_0 got=%0d exp=0", bus.outstanding);
        end
    endtask

    task automatic test_store();
        drive(2'd2, 32'h80, 64'hDEADBEEF, 2'd0, 32'h0, 4'd5, 4'd0);
        sb.push_back(pack_exp(2'd2, 32'h80, 64'hDEADBEEF, 4'd5, 4'd0, 4'd0, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL store_forward got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL store_no_alloc got=%0d exp=0", bus.outstanding);
        end
    endtask

    task automatic test_starvation();
        int unsigned cnt;
        logic        own [16];
        logic [3:0]  rsp;
        logic [31:0] dca;
        logic        ic_wins;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            rsp = (k == 4) ? 4'd0 : 4'(k + 1);
            dca = 32'h1000 + 32'(k * 8);
            ic_wins = (cnt == 3);
            drive(2'd1, dca, 64'h0, 2'd1, 32'h400, rsp, 4'd0);
            if (ic_wins)
                sb.push_back(pack_exp(2'd1, 32'h400, 64'h0, 4'd0, rsp, 4'd0, 4'd0));
            else
                sb.push_back(pack_exp(2'd1, dca, 64'h0, rsp, 4'd0, 4'd0, 4'd0));
            if (rsp != 4'd0) own[rsp] = ic_wins;
            if (ic_wins && rsp != 4'd0) cnt = 0;
            else if (cnt < 3) cnt++;
            @(negedge clock);
            e = sb.pop_front();
            obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
                   bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL starve_cycle_%0d got=%h exp=%h", k, obs, e);
            end
            tick();
        end
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd4) begin
            errors++;
            $display("FAIL starve_outstanding got=%0d exp=4", bus.outstanding);
        end
        for (int t = 1; t <= 4; t++) begin
            drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'(t));
            sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0,
                                  own[t] ? 4'd0 : 4'(t), own[t] ? 4'(t) : 4'd0));
            @(negedge clock);
            e = sb.pop_front();
            obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
                   bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL starve_return_tag%0d got=%h exp=%h", t, obs, e);
            end
            tick();
        end
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL starve_drain got=%0d exp=0", bus.outstanding);
        end
    endtask

    task automatic test_back_to_back();
        drive(2'd1, 32'h500, 64'h0, 2'd0, 32'h0, 4'd2, 4'd0);
        tick();
        // icache takes tag 2 while the dcache's tag 2 returns in the same cycle
        drive(2'd0, 32'h0, 64'h0, 2'd1, 32'h300, 4'd2, 4'd2);
        sb.push_back(pack_exp(2'd1, 32'h300, 64'h0, 4'd0, 4'd2, 4'd2, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL swap_same_cycle got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd2);
        checks++;
        if (bus.outstanding !== 4'd1) begin
            errors++;
            $display("FAIL swap_outstanding got=%0d exp=1", bus.outstanding);
        end
        sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd2));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL swap_new_owner got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd0 || bus.tag_error !== 1'b0) begin
            errors++;
            $display("FAIL swap_drain got=%0d/%0b exp=0/0", bus.outstanding, bus.tag_error);
        end
    endtask

    task automatic test_tag_error();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd7);
        sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL unowned_tag_route got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.tag_error !== 1'b1) begin
            errors++;
            $display("FAIL tag_error_set got=%0b exp=1", bus.tag_error);
        end
        tick();
        tick();
        checks++;
        if (bus.tag_error !== 1'b1) begin
            errors++;
            $display("FAIL tag_error_sticky got=%0b exp=1", bus.tag_error);
        end
    endtask

    task automatic test_reset_outstanding();
        for (int t = 1; t <= 3; t++) begin
            drive(2'd1, 32'h800 + 32'(t * 8), 64'h0, 2'd0, 32'h0, 4'(t), 4'd0);
            tick();
        end
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.outstanding !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_outstanding got=%0d exp=3", bus.outstanding);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.outstanding !== 4'd0 || bus.tag_error !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state got=%0d/%0b exp=0/0", bus.outstanding, bus.tag_error);
        end
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd2);
        sb.push_back(pack_exp(2'd0, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0));
        @(negedge clock);
        e = sb.pop_front();
        obs = {bus.mem_command, bus.mem_addr, bus.mem_data_out,
               bus.dc_response, bus.ic_response, bus.dc_tag, bus.ic_tag};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL forgotten_tag_route got=%h exp=%h", obs, e);
        end
        tick();
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        checks++;
        if (bus.tag_error !== 1'b1 || bus.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL forgotten_tag_error got=%0b/%0d exp=1/0", bus.tag_error, bus.outstanding);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive(2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 4'd0);
        test_reset();
        test_basic_load();
        test_store();
        test_starvation();
        test_back_to_back();
        test_tag_error();
        test_reset_outstanding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
